// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched: frame-rate scheduler choosing one colour per frame and streaming it as pixel words.
module ws2812_frame_sched #(
  parameter int NUM_LEDS     = 2,
  parameter int FRAME_PERIOD = 100000,
  parameter int CYCLE_FRAMES = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        req_a,
  input  logic        req_b,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  input  logic        frame_done,
  output logic        busy,
  output logic [1:0]  cur_src,
  output logic        frame_skip
);
  localparam int TW = $clog2(FRAME_PERIOD + 1);
  localparam int AW = $clog2(CYCLE_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_LATCH} state_t;
  state_t state, state_nx;
  logic [1:0] a_sync, b_sync;
  logic [TW-1:0] tcnt;
  logic [7:0] pcnt;
  logic [AW-1:0] afc;
  logic [2:0] cidx;
  logic tick, xfer;
  logic [23:0] pal, sel_col;
  logic [1:0] sel_src;
  assign tick       = tcnt == TW'(FRAME_PERIOD - 1);
  assign busy       = state != IDLE;
  assign frame_skip = tick && busy;
  assign pix_valid  = state == SEND;
  assign pix_last   = pix_valid && pcnt == 8'(NUM_LEDS - 1);
  assign xfer       = pix_valid && pix_ready;
  // source code doubles as the arbitration key: bit0 = A, bit1 = B
  assign sel_src    = {b_sync[1], a_sync[1]};
  always_comb begin
    pal = cidx == 3'd0 ? 24'hFFFF00 :
          cidx == 3'd1 ? 24'h800080 :
          cidx == 3'd2 ? 24'hFFA500 :
          cidx == 3'd3 ? 24'hFF0000 :
          cidx == 3'd4 ? 24'h00FF00 : 24'h0000FF;
    sel_col = sel_src == 2'd3 ? 24'h00FF00 :
              sel_src == 2'd1 ? 24'hFF0000 :
              sel_src == 2'd2 ? 24'h0000FF : pal;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (tick && en) ? LOAD : IDLE;
      LOAD:    state_nx = SEND;
      SEND:    state_nx = (xfer && pix_last) ? WAIT_LATCH : SEND;
      default: state_nx = frame_done ? IDLE : WAIT_LATCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sync   <= '0;
      b_sync   <= '0;
      tcnt     <= '0;
      pcnt     <= '0;
      afc      <= '0;
      cidx     <= '0;
      pix_data <= '0;
      cur_src  <= '0;
    end else begin
      state  <= state_nx;
      a_sync <= {a_sync[0], req_a};
      b_sync <= {b_sync[0], req_b};
      tcnt   <= tick ? '0 : tcnt + 1'b1;
      if (state == LOAD) begin
        pix_data <= sel_col;
        cur_src  <= sel_src;
      end
      if (xfer) pcnt <= pix_last ? 8'd0 : pcnt + 8'd1;
      if (state == WAIT_LATCH && frame_done && cur_src == 2'd0) begin
        afc  <= afc == AW'(CYCLE_FRAMES - 1) ? '0 : afc + 1'b1;
        if (afc == AW'(CYCLE_FRAMES - 1)) cidx <= cidx == 3'd5 ? 3'd0 : cidx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_ws2812_frame_sched.sv
// tb_ws2812_frame_sched: directed and random checks of the frame scheduler against a frame-level model.
module tb_ws2812_frame_sched;
  localparam int NL = 2;
  localparam int FP = 30;
  localparam int CF = 2;
  logic clk = 0, rst_n = 0, en = 0, req_a = 0, req_b = 0, pix_ready = 1, frame_done = 0;
  logic [23:0] pix_data;
  logic pix_valid, pix_last, busy, frame_skip;
  logic [1:0] cur_src;
  int checks = 0, errors = 0;
  ws2812_frame_sched #(.NUM_LEDS(NL), .FRAME_PERIOD(FP), .CYCLE_FRAMES(CF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_a(req_a), .req_b(req_b),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .frame_done(frame_done), .busy(busy), .cur_src(cur_src), .frame_skip(frame_skip));
  always #5 clk = ~clk;

  // model: a frame is active from its tick until frame_done; colour chosen one cycle in
  int m_t = 0, m_left = 0, m_wcnt = 0, m_auto = 0, m_frames = 0;
  bit m_act = 0, m_load = 0, m_wait = 0, m_a1 = 0, m_a2 = 0, m_b1 = 0, m_b2 = 0, m_tk;
  logic [23:0] m_col = 0;
  logic [1:0] m_src = 0;

  function automatic logic [23:0] pal(int i);
    case (i)
      0: return 24'hFFFF00;
      1: return 24'h800080;
      2: return 24'hFFA500;
      3: return 24'hFF0000;
      4: return 24'h00FF00;
      default: return 24'h0000FF;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_left = 0; m_wcnt = 0; m_auto = 0; m_act = 0; m_load = 0; m_wait = 0;
      m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0; m_col = 0; m_src = 0;
    end else begin
      m_tk = (m_t == FP - 1);
      m_t = m_tk ? 0 : m_t + 1;
      if (!m_act) begin
        if (m_tk && en) begin m_act = 1; m_load = 1; end
      end else if (m_load) begin
        m_load = 0;
        m_left = NL;
        m_src = {m_b2, m_a2};
        m_col = m_src == 3 ? 24'h00FF00 : m_src == 1 ? 24'hFF0000 :
                m_src == 2 ? 24'h0000FF : pal((m_auto / CF) % 6);
      end else if (m_left > 0) begin
        if (pix_ready) begin
          m_left--;
          if (m_left == 0) begin m_wait = 1; m_wcnt = 0; end
        end
      end else begin
        m_wcnt++;
        if (frame_done) begin
          m_act = 0; m_wait = 0; m_frames++;
          if (m_src == 0) m_auto++;
        end
      end
      m_a2 = m_a1; m_b2 = m_b1; m_a1 = req_a; m_b1 = req_b;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_act);
      chk("pix_valid", pix_valid, m_act && !m_load && m_left > 0);
      chk("pix_last", pix_last, m_act && !m_load && m_left == 1);
      chk("pix_data", pix_data, m_col);
      chk("cur_src", cur_src, m_src);
      chk("frame_skip", frame_skip, m_act && m_t == FP - 1);
    end
  end

  // serializer stand-in and transfer log
  int done_dly = 5, skips = 0, lasts = 0;
  bit hold = 0, stray = 0, rnd_ready = 0, ready_lvl = 1;
  logic [23:0] words[$];

  task automatic step();
    @(negedge clk);
    frame_done = (m_wait && m_wcnt >= done_dly && !hold) || (stray && !m_wait && $urandom % 40 == 0);
    pix_ready = rnd_ready ? ($urandom % 4 != 0) : ready_lvl;
    #1;
    if (pix_valid && pix_ready) begin
      words.push_back(pix_data);
      if (pix_last) lasts++;
    end
    if (frame_skip) skips++;
  endtask

  task automatic wait_frames(input int n);
    int target = m_frames + n, cnt = 0;
    while (m_frames < target && cnt < 2000) begin step(); cnt++; end
    if (m_frames < target) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", m_frames, target);
    end
  endtask

  task automatic wait_send();
    int cnt = 0;
    while (!(m_act && !m_load && m_left > 0) && cnt < 500) begin step(); cnt++; end
    if (cnt >= 500) begin
      checks++; errors++;
      $display("FAIL send_timeout: got %0d cycles expected <500", cnt);
    end
  endtask

  logic [23:0] exp_seq[14] = '{24'hFFFF00, 24'hFFFF00, 24'h800080, 24'h0000FF, 24'h800080,
                               24'hFFA500, 24'hFFA500, 24'hFF0000, 24'hFF0000, 24'h00FF00,
                               24'h00FF00, 24'h0000FF, 24'h0000FF, 24'hFFFF00};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_src", cur_src, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_skip", frame_skip, 0);
    @(negedge clk);
    rst_n = 1; en = 1;
    // default auto frame
    words.delete(); lasts = 0;
    wait_frames(1);
    chk("auto_count", words.size(), 2);
    chk("auto_w0", words[0], 24'hFFFF00);
    chk("auto_w1", words[1], 24'hFFFF00);
    chk("auto_last", lasts, 1);
    chk("auto_idle", busy, 0);
    // both requests, released mid-frame
    req_a = 1; req_b = 1; words.delete();
    wait_send();
    req_a = 0; req_b = 0;
    wait_frames(1);
    chk("ab_w0", words[0], 24'h00FF00);
    chk("ab_w1", words[1], 24'h00FF00);
    chk("ab_src", cur_src, 3);
    // stalled serializer
    words.delete(); ready_lvl = 0;
    wait_send();
    repeat (10) step();
    chk("stall_valid", pix_valid, 1);
    chk("stall_data", pix_data, 24'hFFFF00);
    chk("stall_none", words.size(), 0);
    ready_lvl = 1;
    wait_frames(1);
    chk("stall_count", words.size(), 2);
    // frame_done withheld past the next tick
    done_dly = 40; skips = 0;
    wait_frames(1);
    done_dly = 5;
    wait_frames(1);
    chk("skip_pulses", skips, 1);
    // palette walk after a fresh reset, one requester-B frame interleaved
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    words.delete();
    for (int f = 0; f < 14; f++) begin
      req_b = (f == 3);
      wait_frames(1);
    end
    req_b = 0;
    for (int i = 0; i < 14; i++) chk($sformatf("palette_%0d", i), words[2 * i], exp_seq[i]);
    // random traffic
    stray = 1; rnd_ready = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 25 == 0) req_a = ~req_a;
      if ($urandom % 25 == 0) req_b = ~req_b;
      if ($urandom % 150 == 0) en = ($urandom % 4 != 0);
      if (!m_wait) done_dly = $urandom_range(0, 45);
      step();
    end
    // reset in the middle of a frame
    stray = 0; rnd_ready = 0; ready_lvl = 0; en = 1; req_a = 0; req_b = 0; done_dly = 5;
    wait_send();
    @(negedge clk); rst_n = 0;
    #1;
    chk("abort_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1; ready_lvl = 1;
    n = 0;
    while (!pix_valid && n < 200) begin step(); n++; end
    chk("restart_latency", n, FP + 1);
    chk("restart_color", pix_data, 24'hFFFF00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
